// File: rtl/code_decoder_stream_pkg.sv
// rtl/code_decoder_stream_pkg.sv - shared widths, skid state enum and decode helper
package code_dec_pkg;

  localparam int CODE_W_DEF = 3;
  localparam int OUT_W_DEF  = 1 << CODE_W_DEF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } dec_state_e;

  // Binary code to one-hot word; a disabled decode yields no bit set.
  function automatic logic [OUT_W_DEF-1:0] onehot_of(input logic [CODE_W_DEF-1:0] code,
                                                     input logic en);
    logic [OUT_W_DEF-1:0] w;
    w = '0;
    if (en) w[code] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/code_decoder_stream_if.sv
// rtl/code_decoder_stream_if.sv - code input and one-hot output handshake bundle
interface code_decoder_stream_if #(
  parameter int CODE_W = 3
);
  localparam int OUT_W = 1 << CODE_W;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_en;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_onehot;

  modport master (
    output in_valid, in_code, in_en, out_ready,
    input  in_ready, out_valid, out_onehot
  );

  modport slave (
    input  in_valid, in_code, in_en, out_ready,
    output in_ready, out_valid, out_onehot
  );

endinterface

// File: rtl/code_decoder_stream_skid.sv
// rtl/code_decoder_stream_skid.sv - two-slot skid buffer with registered ready
module code_dec_skid
  import code_dec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  dec_state_e   state_q, state_d;
  logic         ready_q;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, emit;

  assign accept = in_valid_i & ready_q;
  assign emit   = (state_q != EMPTY) & out_ready_i;

  // State, ready and slot registers; reset drops any held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Occupancy transitions driven by accept/emit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !emit)      state_d = TWO;
        else if (!accept && emit) state_d = EMPTY;
      end
      TWO:     if (emit) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Slot contents; the output slot is cleared when it empties so idle output reads zero.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (accept) out_d = in_data_i;
      ONE: begin
        if (accept && emit) out_d = in_data_i;
        else if (accept)    skid_d = in_data_i;
        else if (emit)      out_d = '0;
      end
      TWO: begin
        if (emit) begin
          out_d  = skid_q;
          skid_d = '0;
        end
      end
      default: begin
        out_d  = '0;
        skid_d = '0;
      end
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready_o  = ready_q;
    out_valid_o = (state_q != EMPTY);
    out_data_o  = out_q;
  end

endmodule

// File: rtl/code_decoder_stream.sv
// rtl/code_decoder_stream.sv - streaming code-to-one-hot decoder; CODE_DEC_STATS_EN adds per-code emit counters
module code_decoder_stream
  import code_dec_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  code_decoder_stream_if.slave  bus,
  input  logic [CODE_W-1:0]     stat_sel,
  output logic [CNT_W-1:0]      stat_cnt
);

  localparam int OUT_W = 1 << CODE_W;

  logic [OUT_W-1:0] word;
  logic [OUT_W-1:0] out_word;
  logic             out_valid_w;
  logic             in_ready_w;

  if (CODE_W == CODE_W_DEF) begin : g_pkg_dec
    assign word = onehot_of(bus.in_code, bus.in_en);
  end else begin : g_gen_dec
    assign word = bus.in_en ? (OUT_W'(1) << bus.in_code) : '0;
  end

  code_dec_skid #(.W(OUT_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (in_ready_w),
    .in_data_i   (word),
    .out_valid_o (out_valid_w),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_word)
  );

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.out_onehot = out_word;

`ifdef CODE_DEC_STATS_EN
  logic [OUT_W-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        emit;

  assign emit = out_valid_w & bus.out_ready;

  // Bump the counter of the emitted word's set bit, holding at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (emit) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (out_word[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stat_cnt = cnt_q[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_code_decoder_stream.sv
// tb/tb_code_decoder_stream.sv - randomized and directed checks against a queue model
module tb_code_decoder_stream;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CODE_DEC_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CODE_W-1:0] stat_sel = '0;
  logic [CNT_W-1:0]  stat_cnt;

  code_decoder_stream_if #(.CODE_W(CODE_W)) bus ();

  code_decoder_stream #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int prio_enc(input logic [OUT_W-1:0] w);
    for (int i = OUT_W - 1; i >= 0; i--) if (w[i]) return i;
    return 0;
  endfunction

  // Reference model: words in flight, per-code emit counts, and a log of emitted words.
  logic [OUT_W-1:0] q[$];
  int               cnt[OUT_W];
  bit               armed = 1'b0;
  int               cyc = 0;
  logic [OUT_W-1:0] log_w[$];
  int               log_c[$];

  always @(negedge clk) begin : model
    logic [OUT_W-1:0] w;
    bit acc, em;
    cyc++;
    if (armed) begin
      check("out_valid", bus.out_valid, (q.size() != 0));
      check("in_ready", bus.in_ready, (q.size() < 2));
      check("out_onehot", bus.out_onehot, (q.size() != 0) ? q[0] : 8'h00);
      check("stat_cnt", stat_cnt, STATS_ON ? cnt[stat_sel] : 0);
    end
    if (rst) begin
      q.delete();
      for (int i = 0; i < OUT_W; i++) cnt[i] = 0;
      armed = 1'b1;
    end else if (armed) begin
      acc = bus.in_valid && (q.size() < 2);
      em  = bus.out_ready && (q.size() != 0);
      if (em) begin
        w = q.pop_front();
        log_w.push_back(w);
        log_c.push_back(cyc);
        for (int i = 0; i < OUT_W; i++) if (w[i] && cnt[i] < CNT_MAX) cnt[i]++;
      end
      if (acc) q.push_back(bus.in_en ? (8'd1 << bus.in_code) : 8'd0);
    end
  end

  task automatic push(input logic [CODE_W-1:0] code, input logic en);
    bit ok = 1'b0;
    bit r;
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_en    = en;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [OUT_W-1:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [OUT_W-1:0] bp_exp [3]    = '{8'h08, 8'h40, 8'h02};

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_code   = '0;
    bus.in_en     = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_onehot", bus.out_onehot, 0);
    check("reset_stat_cnt", stat_cnt, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // Full sweep with the consumer always ready.
    log_w.delete(); log_c.delete();
    for (int c = 0; c < 8; c++) push(3'(c), 1'b1);
    idle(3);
    check("sweep_count", log_w.size(), 8);
    for (int i = 0; i < 8 && i < log_w.size(); i++) begin
      check("sweep_word", log_w[i], sweep_exp[i]);
      check("sweep_cycle", log_c[i], log_c[0] + i);
    end

    // Decode disabled yields a valid all-zero word and no count.
    log_w.delete();
    stat_sel = 3'd5;
    push(3'd5, 1'b0);
    idle(3);
    check("en_low_count", log_w.size(), 1);
    if (log_w.size() == 1) check("en_low_word", log_w[0], 8'h00);
    check("en_low_stat5", stat_cnt, STATS_ON ? 1 : 0);

    // Backpressure: two words held, third waits.
    log_w.delete();
    bus.out_ready = 1'b0;
    push(3'd3, 1'b1);
    push(3'd6, 1'b1);
    bus.in_valid = 1'b1; bus.in_code = 3'd1; bus.in_en = 1'b1;
    idle(2);
    @(negedge clk);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_word", bus.out_onehot, 8'h08);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    push(3'd1, 1'b1);
    idle(5);
    check("bp_count", log_w.size(), 3);
    for (int i = 0; i < 3 && i < log_w.size(); i++) check("bp_order", log_w[i], bp_exp[i]);

    // Reset while both slots hold words.
    bus.out_ready = 1'b0;
    push(3'd2, 1'b1);
    push(3'd4, 1'b1);
    @(negedge clk);
    check("two_in_ready", bus.in_ready, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    log_w.delete();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    idle(3);
    check("midrst_no_emit", log_w.size(), 0);

    // Saturation and round trip through a priority encoder.
    log_w.delete();
    for (int i = 0; i < 20; i++) push(3'd2, 1'b1);
    idle(3);
    stat_sel = 3'd2;
    #1;
    check("sat_cnt2", stat_cnt, STATS_ON ? 15 : 0);
    stat_sel = 3'd7;
    #1;
    check("sat_cnt7", stat_cnt, 0);
    check("rt_count", log_w.size(), 20);
    for (int i = 0; i < log_w.size(); i++) check("round_trip", prio_enc(log_w[i]), 2);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 199) == 0);
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_code   = 3'($urandom);
      bus.in_en     = ($urandom_range(0, 99) < 85);
      bus.out_ready = ($urandom_range(0, 99) < 65);
      stat_sel      = 3'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(5);
    check("drain_out_valid", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
